// File: rtl/gray_to_binary_seq.sv
// gray_to_binary_seq: sequential Gray-to-binary decoder.
// Accepts one Gray word through a valid/ready input and resolves it MSB-first,
// one bit per clock. The result is then held on a valid/ready output.
//
// Optional feature macro: GRAY_STEP_CHECK_EN
//   When defined, the block adds a prev_gray register and a step_err output.
//   step_err flags a word that differs from the previously accepted word in
//   more than one bit, which is illegal for a Gray-coded counter or pointer.
//
// Handshake rules (both sides): a transfer happens at a rising edge where valid
// and ready are both high. in_ready is high only in IDLE. out_valid is high only
// in DONE, and binary_out/step_err hold steady until the transfer. in_valid is
// ignored while busy, and out_ready is ignored while out_valid is low.
module gray_to_binary_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] binary_out,
    output logic             busy
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic             step_err
`endif
);

    // idx carries one spare bit so the countdown can never wrap inside a word.
    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] g_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH:0]   b_ext;
    logic [IDX_W-1:0] idx;

    // Status flags come straight from the state register.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
    end

    // Resolve the bit at idx: it is the bit above it XOR the Gray bit. A zero is
    // padded above the MSB, so the top bit falls out as a plain copy of g.
    always_comb begin
        b_ext  = {1'b0, b_reg};
        b_next = b_ext[WIDTH-1:0];
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == IDX_W'(i)) begin
                b_next[i] = b_ext[i+1] ^ g_reg[i];
            end
        end
    end

    // Main control: accept, step through the bits, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            g_reg      <= '0;
            b_reg      <= '0;
            idx        <= '0;
            binary_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        g_reg <= gray_in;
                        b_reg <= '0;
                        idx   <= IDX_TOP;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    b_reg <= b_next;
                    if (idx == '0) begin
                        binary_out <= b_next;
                        state      <= ST_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_gray;
    logic             have_prev;
    logic             step_pend;

    // Compare each accepted word with the previous one; publish the flag
    // together with the decoded result and clear it at the output transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray <= '0;
            have_prev <= 1'b0;
            step_pend <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            if (state == ST_IDLE && in_valid) begin
                step_pend <= have_prev && ($countones(prev_gray ^ gray_in) > 1);
                prev_gray <= gray_in;
                have_prev <= 1'b1;
            end
            if (state == ST_DECODE && idx == '0) begin
                step_err <= step_pend;
            end else if (state == ST_DONE && out_ready) begin
                step_err <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_to_binary_seq.sv
// Testbench for gray_to_binary_seq (WIDTH=4). The reference decoder treats each
// binary bit as the parity of all Gray bits at or above it.
module tb_gray_to_binary_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] gray_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] binary_out;
    logic         busy;
`ifdef GRAY_STEP_CHECK_EN
    logic         step_err;
    logic         exp_step_q[$];
    logic [W-1:0] prev_g;
    bit           have_prev;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];

    gray_to_binary_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .gray_in    (gray_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .binary_out (binary_out),
        .busy       (busy)
`ifdef GRAY_STEP_CHECK_EN
        ,
        .step_err   (step_err)
`endif
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_decode(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

`ifdef GRAY_STEP_CHECK_EN
    function automatic int popcount(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(v[i]);
        return n;
    endfunction
`endif

    task automatic model_accept(input logic [W-1:0] g);
        exp_q.push_back(ref_decode(g));
`ifdef GRAY_STEP_CHECK_EN
        exp_step_q.push_back(have_prev && (popcount(prev_g ^ g) > 1));
        prev_g    = g;
        have_prev = 1'b1;
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
`ifdef GRAY_STEP_CHECK_EN
        exp_step_q.delete();
        have_prev = 1'b0;
`endif
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        gray_in   = '0;
        repeat (n) tick();
        model_reset();
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_binary_out", binary_out, 0);
`ifdef GRAY_STEP_CHECK_EN
        check_eq("rst_step_err", step_err, 0);
`endif
        rst = 1'b0;
    endtask

    // Send one word, check latency/result, hold DONE for 'hold' cycles, release.
    task automatic run_word(input logic [W-1:0] g, input int hold, output int acc_cyc);
        int           n;
        logic [W-1:0] exp_b;
`ifdef GRAY_STEP_CHECK_EN
        logic         exp_s;
`endif
        check_eq("pre_in_ready", in_ready, 1);
        in_valid = 1'b1;
        gray_in  = g;
        tick();
        acc_cyc = cyc;
        model_accept(g);
        in_valid = 1'b0;
        gray_in  = W'($urandom);
        check_eq("acc_busy", busy, 1);
        check_eq("acc_in_ready", in_ready, 0);
        n = 0;
        while (!out_valid && n < 4 * W + 8) begin
            tick();
            n++;
        end
        check_eq("latency", n, W);
        exp_b = exp_q.pop_front();
        check_eq("result", binary_out, exp_b);
`ifdef GRAY_STEP_CHECK_EN
        exp_s = exp_step_q.pop_front();
        check_eq("step_err", step_err, exp_s);
`endif
        for (int k = 0; k < hold; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            gray_in   = W'($urandom);
            out_ready = 1'b0;
            tick();
            check_eq("hold_out_valid", out_valid, 1);
            check_eq("hold_result", binary_out, exp_b);
            check_eq("hold_in_ready", in_ready, 0);
`ifdef GRAY_STEP_CHECK_EN
            check_eq("hold_step_err", step_err, exp_s);
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("rel_out_valid", out_valid, 0);
        check_eq("rel_in_ready", in_ready, 1);
        check_eq("rel_busy", busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int a;
        int prev_a;
        logic [W-1:0] g;

        // 1: reset held for two edges
        do_reset(2);

        // out_ready with no result pending does nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("noop_out_valid", out_valid, 0);
        check_eq("noop_in_ready", in_ready, 1);
        check_eq("noop_binary_out", binary_out, 0);

        // 2: directed word
        run_word(4'b1011, 0, a);
        check_eq("t2_const", binary_out, 4'b1101);

        // 3: full Gray sequence, back-to-back, spacing of WIDTH+2 edges
        prev_a = 0;
        for (int b = 0; b < 16; b++) begin
            g = W'(b ^ (b >> 1));
            run_word(g, 0, a);
            check_eq("t3_value", binary_out, b);
            if (b > 0) check_eq("t3_spacing", a - prev_a, W + 2);
            prev_a = a;
        end

        // 4: long hold in DONE with noise on the input side
        run_word(W'($urandom), 10, a);

        // 5: reset on the second DECODE edge drops the word
        in_valid = 1'b1;
        gray_in  = W'($urandom);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_eq("t5_out_valid", out_valid, 0);
        check_eq("t5_in_ready", in_ready, 1);
        check_eq("t5_binary_out", binary_out, 0);
        for (int k = 0; k < W + 2; k++) begin
            tick();
            check_eq("t5_no_valid", out_valid, 0);
        end
        run_word(4'b0110, 0, a);
        check_eq("t5_const", binary_out, 4'b0100);

        // Randomized words with random holds and idle gaps
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            run_word(W'($urandom), $urandom_range(0, 3), a);
        end

`ifdef GRAY_STEP_CHECK_EN
        // 6: step check across a reset boundary
        do_reset(2);
        run_word(4'b0000, 0, a);
        run_word(4'b0001, 1, a);
        run_word(4'b0111, 2, a);
        run_word(4'b0111, 0, a);
        for (int k = 0; k < 20; k++) begin
            run_word(W'($urandom), $urandom_range(0, 2), a);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
